// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Holds the default word width, reset PC, buffer depth and the FSM state encoding.
package fetch_unit_pkg;

    localparam int          WORD_SIZE_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam int          FETCH_BUF_DEPTH = 2;
    localparam int          PC_STEP         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {instruction, PC} pairs.
// Flush wins over push and pop; a push into a full buffer is accepted only alongside a pop.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 2 * WORD_SIZE_DEF,
    parameter int DEPTH = FETCH_BUF_DEPTH,
    localparam int CW   = count_width(DEPTH),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a two-entry buffer toward decode,
// and redirect handling that discards an in-flight response through the DROP state.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE = WORD_SIZE_DEF,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(RESET_PC_DEF)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_ImemReq,
    output logic [WORD_SIZE-1:0] o_ImemAddr,
    input  logic                 i_ImemAck,
    input  logic [WORD_SIZE-1:0] i_ImemData,
    input  logic                 i_Redirect,
    input  logic [WORD_SIZE-1:0] i_RedirectPc,
    output logic                 o_InstrValid,
    output logic [WORD_SIZE-1:0] o_Instr,
    output logic [WORD_SIZE-1:0] o_InstrPc,
    input  logic                 i_InstrReady,
    output fetch_state_t         o_DbgState
);

    localparam int CW = count_width(FETCH_BUF_DEPTH);
    localparam int EW = 2 * WORD_SIZE;

    fetch_state_t         r_state;
    fetch_state_t         w_state_nxt;
    logic                 r_req;
    logic                 w_req_nxt;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] w_addr_nxt;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] w_pc_nxt;
    logic [WORD_SIZE-1:0] w_target;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_room;
    logic [CW:0]          w_occ_after;
    logic [CW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic [EW-1:0]        w_head;

    // Memory side: o_ImemReq/o_ImemAddr hold from issue through the cycle i_ImemAck is high.
    // Decode side: a transfer happens on a rising edge where o_InstrValid && i_InstrReady.
    assign w_pop  = !w_empty && i_InstrReady && !i_Redirect;
    assign w_push = (r_state == ST_WAIT) && i_ImemAck && !i_Redirect && (!w_full || w_pop);

    assign w_target    = i_Redirect ? (i_RedirectPc & ~WORD_SIZE'(3)) : r_pc;
    assign w_occ_after = {1'b0, w_count} + (CW + 1)'(w_push) - (CW + 1)'(w_pop);
    // A new request must still fit once it returns, counting what this edge pushes/pops.
    assign w_room      = i_Redirect || (w_occ_after < (CW + 1)'(FETCH_BUF_DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_pc_nxt    = w_target;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_issue = w_room;
            end
            ST_WAIT: begin
                if (i_ImemAck) begin
                    w_issue = w_room;
                end else if (i_Redirect) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (i_ImemAck) begin
                    w_issue = w_room;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
        if (w_issue) begin
            w_state_nxt = ST_WAIT;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = w_target;
            w_pc_nxt    = w_target + WORD_SIZE'(PC_STEP);
        end else if ((r_state != ST_IDLE) && i_ImemAck) begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    fetch_buffer #(
        .WIDTH (EW),
        .DEPTH (FETCH_BUF_DEPTH)
    ) u_fetch_buffer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata ({i_ImemData, r_addr}),
        .i_pop   (w_pop),
        .i_flush (i_Redirect),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign o_ImemReq    = r_req;
    assign o_ImemAddr   = r_addr;
    assign o_InstrValid = !w_empty;
    assign o_Instr      = w_empty ? '0 : w_head[EW-1:WORD_SIZE];
    assign o_InstrPc    = w_empty ? '0 : w_head[WORD_SIZE-1:0];
    assign o_DbgState   = r_state;

    a_req_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_req && !i_ImemAck) |=> (r_req && $stable(r_addr)));

    a_ack_needs_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_ImemAck |-> r_req);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a sequential-PC reference model with a latency-varying memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         o_ImemReq;
  logic [W-1:0] o_ImemAddr;
  logic         i_ImemAck = 1'b0;
  logic [W-1:0] i_ImemData = '0;
  logic         i_Redirect = 1'b0;
  logic [W-1:0] i_RedirectPc = '0;
  logic         o_InstrValid;
  logic [W-1:0] o_Instr;
  logic [W-1:0] o_InstrPc;
  logic         i_InstrReady = 1'b0;
  fetch_state_t o_DbgState;

  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  int mem_lat = 1;
  bit mem_block = 1'b0;
  int mem_cnt = 0;
  int mem_cur = 0;

  fetch_unit dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_ImemReq    (o_ImemReq),
    .o_ImemAddr   (o_ImemAddr),
    .i_ImemAck    (i_ImemAck),
    .i_ImemData   (i_ImemData),
    .i_Redirect   (i_Redirect),
    .i_RedirectPc (i_RedirectPc),
    .o_InstrValid (o_InstrValid),
    .o_Instr      (o_Instr),
    .o_InstrPc    (o_InstrPc),
    .i_InstrReady (i_InstrReady),
    .o_DbgState   (o_DbgState)
  );

  // clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h0001_0003) ^ 32'hC3C3_5A5A;
  endfunction

  // memory model: acks the outstanding request after mem_lat cycles (random 1..3 when 0)
  always @(negedge i_clk) begin
    i_ImemAck  = 1'b0;
    i_ImemData = $urandom;
    if (!i_rst_n) begin
      mem_cnt = 0;
      mem_cur = 0;
    end else if (o_ImemReq && !mem_block) begin
      if (mem_cur == 0) mem_cur = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
      mem_cnt = mem_cnt + 1;
      if (mem_cnt >= mem_cur) begin
        i_ImemAck  = 1'b1;
        i_ImemData = mem_word(o_ImemAddr);
        mem_cnt    = 0;
        mem_cur    = 0;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input bit rdy);
    i_rst_n      = 1'b0;
    i_Redirect   = 1'b0;
    i_InstrReady = rdy;
    mem_lat      = lat;
    mem_block    = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    step();
    n_total++; if (o_ImemReq !== 1'b0) $display("FAIL reset_req: got %0b want 0", o_ImemReq); else n_pass++;
    n_total++; if (o_ImemAddr !== 32'h0) $display("FAIL reset_addr: got %h want 0", o_ImemAddr); else n_pass++;
    n_total++; if (o_InstrValid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", o_InstrValid); else n_pass++;
    n_total++; if (o_Instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", o_Instr); else n_pass++;
    n_total++; if (o_InstrPc !== 32'h0) $display("FAIL reset_instr_pc: got %h want 0", o_InstrPc); else n_pass++;
    n_total++; if (o_DbgState !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", o_DbgState, ST_IDLE); else n_pass++;
    i_rst_n = 1'b1;
    step();
    n_total++; if (o_ImemReq !== 1'b1) $display("FAIL first_req: got %0b want 1", o_ImemReq); else n_pass++;
    n_total++; if (o_ImemAddr !== 32'h0) $display("FAIL first_addr: got %h want 0", o_ImemAddr); else n_pass++;
    n_total++; if (o_DbgState !== ST_WAIT) $display("FAIL first_state: got %0d want %0d", o_DbgState, ST_WAIT); else n_pass++;
  endtask

  task automatic test_stream();
    bit seen = 1'b0;
    logic [W-1:0] e;
    do_reset(1, 1'b1);
    exp_q.delete();
    for (int k = 0; k < 10; k++) exp_q.push_back(W'(4 * k));
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      step();
      if (seen) begin
        n_total++; if (o_InstrValid !== 1'b1) $display("FAIL stream_gap: got valid %0b want 1 at cycle %0d", o_InstrValid, cyc); else n_pass++;
      end
      if (o_InstrValid === 1'b1) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        n_total++; if (o_InstrPc !== e) $display("FAIL stream_pc: got %h want %h", o_InstrPc, e); else n_pass++;
        n_total++; if (o_Instr !== mem_word(e)) $display("FAIL stream_instr: got %h want %h", o_Instr, mem_word(e)); else n_pass++;
      end
    end
    n_total++; if (exp_q.size() != 0) $display("FAIL stream_timeout: got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_pressure();
    do_reset(1, 1'b0);
    for (int k = 0; k < 6; k++) step();
    n_total++; if (o_InstrValid !== 1'b1) $display("FAIL bp_valid: got %0b want 1", o_InstrValid); else n_pass++;
    n_total++; if (o_InstrPc !== 32'h0) $display("FAIL bp_head: got %h want 0", o_InstrPc); else n_pass++;
    n_total++; if (o_DbgState !== ST_IDLE) $display("FAIL bp_state: got %0d want %0d", o_DbgState, ST_IDLE); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++; if (o_ImemReq !== 1'b0) $display("FAIL bp_no_issue: got %0b want 0", o_ImemReq); else n_pass++;
      step();
    end
    i_InstrReady = 1'b1;
    step();
    i_InstrReady = 1'b0;
    n_total++; if (o_InstrPc !== 32'h4) $display("FAIL bp_pop_head: got %h want 4", o_InstrPc); else n_pass++;
    n_total++; if (o_ImemReq !== 1'b1) $display("FAIL bp_reissue: got %0b want 1", o_ImemReq); else n_pass++;
    n_total++; if (o_ImemAddr !== 32'h8) $display("FAIL bp_reissue_addr: got %h want 8", o_ImemAddr); else n_pass++;
    step();
    n_total++; if (o_ImemReq !== 1'b0) $display("FAIL bp_refull: got %0b want 0", o_ImemReq); else n_pass++;
    n_total++; if (o_InstrPc !== 32'h4) $display("FAIL bp_refull_head: got %h want 4", o_InstrPc); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit found = 1'b0;
    do_reset(1, 1'b1);
    mem_block = 1'b1;
    step();
    n_total++; if (o_DbgState !== ST_WAIT) $display("FAIL rw_pre_state: got %0d want %0d", o_DbgState, ST_WAIT); else n_pass++;
    i_Redirect   = 1'b1;
    i_RedirectPc = 32'h0000_0103;
    step();
    i_Redirect = 1'b0;
    n_total++; if (o_DbgState !== ST_DROP) $display("FAIL rw_drop: got %0d want %0d", o_DbgState, ST_DROP); else n_pass++;
    n_total++; if (o_ImemAddr !== 32'h0) $display("FAIL rw_addr_held: got %h want 0", o_ImemAddr); else n_pass++;
    step();
    step();
    n_total++; if (o_ImemReq !== 1'b1 || o_ImemAddr !== 32'h0) $display("FAIL rw_still_held: got req %0b addr %h want 1 0", o_ImemReq, o_ImemAddr); else n_pass++;
    mem_block = 1'b0;
    step();
    step();
    n_total++; if (o_InstrValid !== 1'b0) $display("FAIL rw_dropped: got valid %0b want 0", o_InstrValid); else n_pass++;
    n_total++; if (o_ImemReq !== 1'b1 || o_ImemAddr !== 32'h100) $display("FAIL rw_new_req: got req %0b addr %h want 1 100", o_ImemReq, o_ImemAddr); else n_pass++;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      step();
      if (o_InstrValid === 1'b1) begin
        found = 1'b1;
        n_total++; if (o_InstrPc !== 32'h100 || o_Instr !== mem_word(32'h100)) $display("FAIL rw_first_instr: got %h/%h want 100/%h", o_InstrPc, o_Instr, mem_word(32'h100)); else n_pass++;
      end
    end
    n_total++; if (!found) $display("FAIL rw_timeout: got no instruction want pc 100"); else n_pass++;
  endtask

  task automatic test_redirect_ack();
    bit found = 1'b0;
    do_reset(1, 1'b0);
    step();
    step();
    n_total++; if (o_InstrValid !== 1'b1 || i_ImemAck !== 1'b1 || o_ImemAddr !== 32'h4) $display("FAIL ra_setup: got valid %0b ack %0b addr %h want 1 1 4", o_InstrValid, i_ImemAck, o_ImemAddr); else n_pass++;
    i_Redirect   = 1'b1;
    i_RedirectPc = 32'h0000_0200;
    step();
    i_Redirect = 1'b0;
    n_total++; if (o_InstrValid !== 1'b0) $display("FAIL ra_flush: got valid %0b want 0", o_InstrValid); else n_pass++;
    n_total++; if (o_ImemReq !== 1'b1 || o_ImemAddr !== 32'h200) $display("FAIL ra_new_req: got req %0b addr %h want 1 200", o_ImemReq, o_ImemAddr); else n_pass++;
    i_InstrReady = 1'b1;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      step();
      if (o_InstrValid === 1'b1) begin
        found = 1'b1;
        n_total++; if (o_InstrPc !== 32'h200) $display("FAIL ra_first_pc: got %h want 200", o_InstrPc); else n_pass++;
      end
    end
    n_total++; if (!found) $display("FAIL ra_timeout: got no instruction want pc 200"); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    do_reset(1, 1'b1);
    step();
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    i_Redirect   = 1'b1;
    i_RedirectPc = 32'hFFFF_FFFC;
    step();
    i_Redirect = 1'b0;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      step();
      if (o_InstrValid === 1'b1) begin
        e = exp_q.pop_front();
        n_total++; if (o_InstrPc !== e || o_Instr !== mem_word(e)) $display("FAIL wrap_pc: got %h/%h want %h/%h", o_InstrPc, o_Instr, e, mem_word(e)); else n_pass++;
      end
    end
    n_total++; if (exp_q.size() != 0) $display("FAIL wrap_timeout: got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    bit found = 1'b0;
    do_reset(1, 1'b0);
    step();
    mem_block = 1'b1;
    step();
    n_total++; if (o_InstrValid !== 1'b1 || o_ImemAddr !== 32'h4 || o_DbgState !== ST_WAIT) $display("FAIL rm_setup: got valid %0b addr %h state %0d want 1 4 %0d", o_InstrValid, o_ImemAddr, o_DbgState, ST_WAIT); else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_total++; if (o_ImemReq !== 1'b0) $display("FAIL rm_req: got %0b want 0", o_ImemReq); else n_pass++;
    n_total++; if (o_ImemAddr !== 32'h0) $display("FAIL rm_addr: got %h want 0", o_ImemAddr); else n_pass++;
    n_total++; if (o_InstrValid !== 1'b0 || o_Instr !== 32'h0 || o_InstrPc !== 32'h0) $display("FAIL rm_outputs: got %0b %h %h want 0 0 0", o_InstrValid, o_Instr, o_InstrPc); else n_pass++;
    n_total++; if (o_DbgState !== ST_IDLE) $display("FAIL rm_state: got %0d want %0d", o_DbgState, ST_IDLE); else n_pass++;
    mem_block = 1'b0;
    mem_lat   = 1;
    step();
    step();
    i_rst_n = 1'b1;
    step();
    n_total++; if (o_ImemReq !== 1'b1 || o_ImemAddr !== 32'h0) $display("FAIL rm_refetch: got req %0b addr %h want 1 0", o_ImemReq, o_ImemAddr); else n_pass++;
    i_InstrReady = 1'b1;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      step();
      if (o_InstrValid === 1'b1) begin
        found = 1'b1;
        n_total++; if (o_InstrPc !== 32'h0 || o_Instr !== mem_word(32'h0)) $display("FAIL rm_first_instr: got %h/%h want 0/%h", o_InstrPc, o_Instr, mem_word(32'h0)); else n_pass++;
      end
    end
    n_total++; if (!found) $display("FAIL rm_timeout: got no instruction want pc 0"); else n_pass++;
  endtask

  // reference model: decode sees consecutive PCs, restarting at each aligned redirect target
  task automatic test_random();
    logic [W-1:0] exp_pc = 32'h0;
    logic [W-1:0] tgt;
    logic         prev_req = 1'b0;
    logic         prev_ack = 1'b0;
    logic [W-1:0] prev_addr = '0;
    int pops = 0;
    do_reset(0, 1'b1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (prev_req && !prev_ack) begin
        n_total++; if (o_ImemReq !== 1'b1 || o_ImemAddr !== prev_addr) $display("FAIL rnd_req_hold: got req %0b addr %h want 1 %h", o_ImemReq, o_ImemAddr, prev_addr); else n_pass++;
      end
      i_InstrReady = ($urandom_range(0, 3) != 0);
      i_Redirect   = ($urandom_range(0, 24) == 0);
      tgt          = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | W'($urandom_range(0, 15))) : W'($urandom);
      i_RedirectPc = tgt;
      if (i_Redirect) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (o_InstrValid === 1'b1 && i_InstrReady) begin
        n_total++; if (o_InstrPc !== exp_pc || o_Instr !== mem_word(exp_pc)) $display("FAIL rnd_pop: got %h/%h want %h/%h", o_InstrPc, o_Instr, exp_pc, mem_word(exp_pc)); else n_pass++;
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_req  = o_ImemReq;
      prev_ack  = i_ImemAck;
      prev_addr = o_ImemAddr;
    end
    i_Redirect = 1'b0;
    n_total++; if (pops < 50) $display("FAIL rnd_progress: got %0d pops want at least 50", pops); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
